// File: rtl/tinyqv_bus_responder.sv
// Bus responder for the CPU's external-device port: 64-byte window, scratch register, byte FIFO.
// Latency WAIT_CYCLES+1 from request capture to data_ready; one transaction per WAIT_CYCLES+3 cycles; FIFO pops on read completion.
module tinyqv_bus_responder #(
    parameter logic [27:0] BASE_ADDR   = 28'h800_0000,
    parameter int          WAIT_CYCLES = 1,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [27:0] data_addr,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    input  logic        data_read_complete,
    input  logic [31:0] data_out,
    output logic        data_ready,
    output logic [31:0] data_in,
    output logic        fifo_irq
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [3:0]    WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    localparam logic [3:0] REG_SCRATCH = 4'h0;
    localparam logic [3:0] REG_FIFO    = 4'h1;
    localparam logic [3:0] REG_STATUS  = 4'h2;
    localparam logic [3:0] REG_CTRL    = 4'h3;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_TURN} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_wcnt;
    logic [3:0]    w_wcnt_next;
    logic          w_capture;

    logic [5:0]    r_off;
    logic [1:0]    r_size;
    logic          r_is_wr;
    logic [31:0]   r_wdata;

    logic [31:0]   r_scratch;
    logic [31:0]   w_scratch_next;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_pop_pend;

    logic          w_hit;
    logic          w_req_wr;
    logic          w_resp;
    logic [3:0]    w_reg;
    logic          w_commit;
    logic          w_push_req;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_arm;
    logic          w_empty;
    logic          w_full;
    logic [3:0]    w_cnt4;
    logic [31:0]   w_rdata;

    assign w_hit    = (data_addr[27:6] == BASE_ADDR[27:6]) &&
                      ((data_write_n != 2'b11) || (data_read_n != 2'b11));
    assign w_req_wr = (data_write_n != 2'b11);

    always_comb begin
        w_next      = r_state;
        w_wcnt_next = r_wcnt;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_next = S_RESP;
                    end else begin
                        w_next      = S_WAIT;
                        w_wcnt_next = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_wcnt == 4'd0) begin
                    w_next = S_RESP;
                end else begin
                    w_wcnt_next = r_wcnt - 4'd1;
                end
            end
            S_RESP:  w_next = S_TURN;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_wcnt  <= 4'd0;
            r_off   <= 6'd0;
            r_size  <= 2'b11;
            r_is_wr <= 1'b0;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_next;
            r_wcnt  <= w_wcnt_next;
            if (w_capture) begin
                r_off   <= data_addr[5:0];
                r_size  <= w_req_wr ? data_write_n : data_read_n;
                r_is_wr <= w_req_wr;
                r_wdata <= data_out;
            end
        end
    end

    assign w_resp     = (r_state == S_RESP);
    assign w_reg      = r_off[5:2];
    assign w_commit   = w_resp && r_is_wr;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_push_req = w_commit && (w_reg == REG_FIFO);
    assign w_push     = w_push_req && !w_full;
    assign w_flush    = w_commit && (w_reg == REG_CTRL) && r_wdata[0];
    assign w_pop      = r_pop_pend && data_read_complete && !w_empty;
    assign w_arm      = w_resp && !r_is_wr && (w_reg == REG_FIFO) && !w_empty;
    assign w_cnt4     = 4'(r_count);

    always_comb begin
        w_scratch_next = r_scratch;
        case (r_size)
            2'b00:   w_scratch_next[8*r_off[1:0] +: 8] = r_wdata[7:0];
            2'b01:   w_scratch_next[16*r_off[1] +: 16] = r_wdata[15:0];
            default: w_scratch_next = r_wdata;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_scratch <= 32'd0;
        end else if (w_commit && (w_reg == REG_SCRATCH)) begin
            r_scratch <= w_scratch_next;
        end
    end

    // Flush has priority over a same-cycle pop; push and flush never coincide.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_push_req && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_wdata[7:0];
        end
    end

    // A new arm in the same cycle as a completion replaces the consumed one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pop_pend <= 1'b0;
        end else if (w_arm) begin
            r_pop_pend <= 1'b1;
        end else if (data_read_complete && r_pop_pend) begin
            r_pop_pend <= 1'b0;
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        if (w_resp && !r_is_wr) begin
            case (w_reg)
                REG_SCRATCH: w_rdata = r_scratch >> {r_off[1:0], 3'b000};
                REG_FIFO:    w_rdata = w_empty ? 32'd0 : {24'd0, r_mem[r_rd_ptr]};
                REG_STATUS:  w_rdata = {24'd0, w_cnt4, 1'b0, r_ovf, w_full, w_empty};
                default:     w_rdata = 32'd0;
            endcase
        end
    end

    assign data_ready = w_resp;
    assign data_in    = w_rdata;
    assign fifo_irq   = !w_empty;

endmodule

// File: tb/tb_tinyqv_bus_responder.sv
// Directed bench for tinyqv_bus_responder: u_dut uses defaults (WAIT_CYCLES=1, depth 4),
// u_dut3 uses WAIT_CYCLES=3 and is held in reset until the mid-transaction reset scenario.
module tb_tinyqv_bus_responder;

    localparam logic [27:0] B = 28'h800_0000;

    logic        clk = 1'b0;
    logic        rstn, rstn2;
    logic [27:0] addr;
    logic [1:0]  wn, rn;
    logic        rc;
    logic [31:0] dout;
    logic        rdy, rdy2, irq, irq2;
    logic [31:0] din, din2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tinyqv_bus_responder u_dut (
        .clk(clk), .rstn(rstn), .data_addr(addr), .data_write_n(wn), .data_read_n(rn),
        .data_read_complete(rc), .data_out(dout), .data_ready(rdy), .data_in(din), .fifo_irq(irq)
    );

    tinyqv_bus_responder #(.WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rstn(rstn2), .data_addr(addr), .data_write_n(wn), .data_read_n(rn),
        .data_read_complete(rc), .data_out(dout), .data_ready(rdy2), .data_in(din2), .fifo_irq(irq2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge with the target idle; returns after TURN so the next call may start.
    task automatic txn(input bit sel2, input logic [27:0] a, input logic [1:0] w, input logic [1:0] r,
                       input logic [31:0] d, output logic [31:0] rd, output int lat);
        addr = a; wn = w; rn = r; dout = d;
        lat = -1;
        rd  = 32'hBAD0_BAD0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if ((sel2 ? rdy2 : rdy) === 1'b1) begin
                lat = i;
                rd  = sel2 ? din2 : din;
                break;
            end
        end
        wn = 2'b11; rn = 2'b11;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        int          seen;
        logic [7:0]  pv [5];

        pv = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        rstn = 1'b0; rstn2 = 1'b0;
        addr = '0; wn = 2'b11; rn = 2'b11; rc = 1'b0; dout = '0;

        #12;
        chk("reset_ready", 32'(rdy), 32'd0);
        chk("reset_data_in", din, 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_ready_w3", 32'(rdy2), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        txn(0, B, 2'b10, 2'b11, 32'hDEADBEEF, rd, lat);
        chk("word_wr_latency", 32'(lat), 32'd2);
        txn(0, B, 2'b11, 2'b10, 32'h0, rd, lat);
        chk("word_rd_latency", 32'(lat), 32'd2);
        chk("word_rd_data", rd, 32'hDEADBEEF);

        txn(0, B + 28'h2, 2'b00, 2'b11, 32'hFFFF_FF55, rd, lat);
        txn(0, B, 2'b01, 2'b11, 32'hFFFF_1234, rd, lat);
        txn(0, B, 2'b11, 2'b10, 32'h0, rd, lat);
        chk("subword_word_rd", rd, 32'hDE551234);
        txn(0, B + 28'h3, 2'b11, 2'b00, 32'h0, rd, lat);
        chk("byte_rd_lane3", rd, 32'h000000DE);
        txn(0, B + 28'h2, 2'b11, 2'b01, 32'h0, rd, lat);
        chk("half_rd_upper", rd, 32'h0000DE55);

        txn(0, B, 2'b10, 2'b10, 32'hA5A5A5A5, rd, lat);
        txn(0, B, 2'b11, 2'b10, 32'h0, rd, lat);
        chk("write_priority", rd, 32'hA5A5A5A5);

        txn(0, B + 28'h8, 2'b11, 2'b10, 32'h0, rd, lat);
        chk("status_initial", rd, 32'h01);
        for (int i = 0; i < 5; i++) begin
            txn(0, B + 28'h4, 2'b00, 2'b11, {24'd0, pv[i]}, rd, lat);
        end
        txn(0, B + 28'h8, 2'b11, 2'b10, 32'h0, rd, lat);
        chk("status_full_ovf", rd, 32'h46);
        chk("irq_full", 32'(irq), 32'd1);
        txn(0, B + 28'hC, 2'b10, 2'b11, 32'h1, rd, lat);
        txn(0, B + 28'h8, 2'b11, 2'b10, 32'h0, rd, lat);
        chk("status_after_flush", rd, 32'h01);
        chk("irq_after_flush", 32'(irq), 32'd0);
        txn(0, B + 28'hC, 2'b11, 2'b10, 32'h0, rd, lat);
        chk("ctrl_read_zero", rd, 32'h0);

        txn(0, B + 28'h4, 2'b00, 2'b11, 32'hA1, rd, lat);
        chk("irq_after_push", 32'(irq), 32'd1);
        txn(0, B + 28'h4, 2'b11, 2'b10, 32'h0, rd, lat);
        chk("fifo_rd_data", rd, 32'hA1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("irq_hold_until_complete", 32'(irq), 32'd1);
        end
        txn(0, B + 28'h8, 2'b11, 2'b10, 32'h0, rd, lat);
        chk("status_before_complete", rd, 32'h10);
        rc = 1'b1;
        @(posedge clk); #1;
        rc = 1'b0;
        chk("irq_after_pop", 32'(irq), 32'd0);
        txn(0, B + 28'h8, 2'b11, 2'b10, 32'h0, rd, lat);
        chk("status_after_pop", rd, 32'h01);

        txn(0, B + 28'h4, 2'b11, 2'b10, 32'h0, rd, lat);
        chk("empty_fifo_rd", rd, 32'h0);
        txn(0, B + 28'h4, 2'b00, 2'b11, 32'h77, rd, lat);
        rc = 1'b1;
        @(posedge clk); #1;
        rc = 1'b0;
        txn(0, B + 28'h8, 2'b11, 2'b10, 32'h0, rd, lat);
        chk("stray_complete_ignored", rd, 32'h10);
        txn(0, B + 28'h4, 2'b11, 2'b10, 32'h0, rd, lat);
        chk("fifo_rd_second", rd, 32'h77);
        rc = 1'b1;
        @(posedge clk); #1;
        rc = 1'b0;
        txn(0, B + 28'h8, 2'b11, 2'b10, 32'h0, rd, lat);
        chk("status_final_empty", rd, 32'h01);

        addr = B + 28'h40; rn = 2'b10;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (rdy === 1'b1) seen++;
        end
        rn = 2'b11;
        @(posedge clk); #1;
        chk("miss_no_ready", 32'(seen), 32'd0);
        txn(0, B + 28'h10, 2'b11, 2'b10, 32'h0, rd, lat);
        chk("unmapped_latency", 32'(lat), 32'd2);
        chk("unmapped_data", rd, 32'h0);

        rstn2 = 1'b1;
        @(posedge clk); #1;
        addr = B; wn = 2'b10; rn = 2'b11; dout = 32'hFFFFFFFF;
        seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (rdy2 === 1'b1) seen++;
        end
        rstn2 = 1'b0;
        #1;
        chk("w3_ready_in_reset", 32'(rdy2), 32'd0);
        wn = 2'b11;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn2 = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (rdy2 === 1'b1) seen++;
        end
        chk("w3_no_ready_after_abort", 32'(seen), 32'd0);
        txn(1, B, 2'b11, 2'b10, 32'h0, rd, lat);
        chk("w3_rd_latency", 32'(lat), 32'd4);
        chk("w3_scratch_zero", rd, 32'h0);
        txn(1, B, 2'b10, 2'b11, 32'hCAFEF00D, rd, lat);
        chk("w3_wr_latency", 32'(lat), 32'd4);
        txn(1, B, 2'b11, 2'b10, 32'h0, rd, lat);
        chk("w3_scratch_after", rd, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
